// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the execute-stage ALU.
//  - Captures the decoded instruction from ID (controls, operands, immediate).
//  - Forwards EX/MEM and MEM/WB results onto the registered rs1/rs2 operands
//    (EX/MEM has priority, x0 is never forwarded).
//  - Selects immediate vs forwarded rs2 for srcB; storeData is always rs2.
//  - Detects load-use hazards: stalls ID (idReady_o=0) and injects a bubble.
//  - Honours branch flush (bubble) and downstream hold (freeze).
//  - Keeps a saturating count of load-use bubbles.
// Ports
//  clk_i, rstN_i                      clock, synchronous active-low reset
//  id*_i                              decoded instruction from ID
//  idReady_o                          stage accepts ID instruction this cycle
//  exmem*_i, memwb*_i                 forwarding sources (MEM, WB)
//  flush_i, exHold_i                  kill entering instruction / freeze stage
//  aluCntrl_o, inv_o, srcA_o, srcB_o  ALU inputs
//  storeData_o                        forwarded rs2 for stores
//  ex*_o                              registered controls
//  luBubbleCnt_o                      saturating load-use bubble count
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rstN_i,
    input  logic            idValid_i,
    output logic            idReady_o,
    input  logic [3:0]      idAluCntrl_i,
    input  logic            idInv_i,
    input  logic [REGW-1:0] idRs1_i,
    input  logic [REGW-1:0] idRs2_i,
    input  logic            idUseRs1_i,
    input  logic            idUseRs2_i,
    input  logic [XLEN-1:0] idRs1Val_i,
    input  logic [XLEN-1:0] idRs2Val_i,
    input  logic [XLEN-1:0] idImm_i,
    input  logic            idUseImm_i,
    input  logic [REGW-1:0] idRd_i,
    input  logic            idRegWrite_i,
    input  logic            idMemRead_i,
    input  logic            idMemWrite_i,
    input  logic            idBranch_i,
    input  logic [REGW-1:0] exmemRd_i,
    input  logic            exmemRegWrite_i,
    input  logic [XLEN-1:0] exmemResult_i,
    input  logic [REGW-1:0] memwbRd_i,
    input  logic            memwbRegWrite_i,
    input  logic [XLEN-1:0] memwbResult_i,
    input  logic            flush_i,
    input  logic            exHold_i,
    output logic [3:0]      aluCntrl_o,
    output logic            inv_o,
    output logic [XLEN-1:0] srcA_o,
    output logic [XLEN-1:0] srcB_o,
    output logic [XLEN-1:0] storeData_o,
    output logic            exValid_o,
    output logic [REGW-1:0] exRd_o,
    output logic            exRegWrite_o,
    output logic            exMemRead_o,
    output logic            exMemWrite_o,
    output logic            exBranch_o,
    output logic [CNTW-1:0] luBubbleCnt_o
);

    typedef struct packed {
        logic            valid;
        logic [3:0]      aluCntrl;
        logic            inv;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [XLEN-1:0] rs1Val;
        logic [XLEN-1:0] rs2Val;
        logic [XLEN-1:0] imm;
        logic            useImm;
        logic [REGW-1:0] rd;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic            branch;
    } ex_fields_t;

    ex_fields_t      ex_d, ex_q;
    ex_fields_t      id_s;
    logic [CNTW-1:0] cnt_d, cnt_q;
    logic            loadUse_s;

    // Forward a newer result onto a registered source operand; EX/MEM wins, x0 never forwarded.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [REGW-1:0] rs,
        input logic [XLEN-1:0] regVal,
        input logic [REGW-1:0] mRd,
        input logic            mWr,
        input logic [XLEN-1:0] mRes,
        input logic [REGW-1:0] wRd,
        input logic            wWr,
        input logic [XLEN-1:0] wRes
    );
        logic [XLEN-1:0] r;
        if (mWr && (mRd != '0) && (mRd == rs)) begin
            r = mRes;
        end else if (wWr && (wRd != '0) && (wRd == rs)) begin
            r = wRes;
        end else begin
            r = regVal;
        end
        return r;
    endfunction

    // Gather the ID-side fields into one capture word.
    always_comb begin
        id_s          = '0;
        id_s.valid    = idValid_i;
        id_s.aluCntrl = idAluCntrl_i;
        id_s.inv      = idInv_i;
        id_s.rs1      = idRs1_i;
        id_s.rs2      = idRs2_i;
        id_s.rs1Val   = idRs1Val_i;
        id_s.rs2Val   = idRs2Val_i;
        id_s.imm      = idImm_i;
        id_s.useImm   = idUseImm_i;
        id_s.rd       = idRd_i;
        id_s.regWrite = idRegWrite_i;
        id_s.memRead  = idMemRead_i;
        id_s.memWrite = idMemWrite_i;
        id_s.branch   = idBranch_i;
    end

    // Load in EX whose destination is a source the ID instruction really reads.
    always_comb begin
        loadUse_s = ex_q.valid && ex_q.memRead && (ex_q.rd != '0) && idValid_i &&
                    ((idUseRs1_i && (idRs1_i == ex_q.rd)) ||
                     (idUseRs2_i && (idRs2_i == ex_q.rd)));
        idReady_o = !exHold_i && !loadUse_s;
    end

    // Next-state selection: hold > flush > load-use bubble > capture.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (exHold_i) begin
            ex_d = ex_q;
        end else if (flush_i) begin
            // A flushed load-use slot is not counted: the bubble is due to the branch.
            ex_d = '0;
        end else if (loadUse_s) begin
            ex_d = '0;
            if (cnt_q != {CNTW{1'b1}}) begin
                cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            ex_d = id_s;
        end
    end

    // Pipeline register and bubble counter with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    // Operand forwarding and ALU source selection.
    always_comb begin
        srcA_o      = fwd_operand(ex_q.rs1, ex_q.rs1Val, exmemRd_i, exmemRegWrite_i, exmemResult_i,
                                  memwbRd_i, memwbRegWrite_i, memwbResult_i);
        storeData_o = fwd_operand(ex_q.rs2, ex_q.rs2Val, exmemRd_i, exmemRegWrite_i, exmemResult_i,
                                  memwbRd_i, memwbRegWrite_i, memwbResult_i);
        if (ex_q.useImm) begin
            srcB_o = ex_q.imm;
        end else begin
            srcB_o = storeData_o;
        end
    end

    assign aluCntrl_o    = ex_q.aluCntrl;
    assign inv_o         = ex_q.inv;
    assign exValid_o     = ex_q.valid;
    assign exRd_o        = ex_q.rd;
    assign exRegWrite_o  = ex_q.regWrite;
    assign exMemRead_o   = ex_q.memRead;
    assign exMemWrite_o  = ex_q.memWrite;
    assign exBranch_o    = ex_q.branch;
    assign luBubbleCnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed test of id_ex_stage with hand-computed expected values.
// A narrow bubble counter keeps the saturation case short.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 4;

    logic            clk_i = 1'b0;
    logic            rstN_i;
    logic            idValid_i;
    logic            idReady_o;
    logic [3:0]      idAluCntrl_i;
    logic            idInv_i;
    logic [REGW-1:0] idRs1_i, idRs2_i;
    logic            idUseRs1_i, idUseRs2_i;
    logic [XLEN-1:0] idRs1Val_i, idRs2Val_i, idImm_i;
    logic            idUseImm_i;
    logic [REGW-1:0] idRd_i;
    logic            idRegWrite_i, idMemRead_i, idMemWrite_i, idBranch_i;
    logic [REGW-1:0] exmemRd_i, memwbRd_i;
    logic            exmemRegWrite_i, memwbRegWrite_i;
    logic [XLEN-1:0] exmemResult_i, memwbResult_i;
    logic            flush_i, exHold_i;
    logic [3:0]      aluCntrl_o;
    logic            inv_o;
    logic [XLEN-1:0] srcA_o, srcB_o, storeData_o;
    logic            exValid_o;
    logic [REGW-1:0] exRd_o;
    logic            exRegWrite_o, exMemRead_o, exMemWrite_o, exBranch_o;
    logic [CNTW-1:0] luBubbleCnt_o;

    int checks_r   = 0;
    int failures_r = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk_i(clk_i), .rstN_i(rstN_i),
        .idValid_i(idValid_i), .idReady_o(idReady_o),
        .idAluCntrl_i(idAluCntrl_i), .idInv_i(idInv_i),
        .idRs1_i(idRs1_i), .idRs2_i(idRs2_i),
        .idUseRs1_i(idUseRs1_i), .idUseRs2_i(idUseRs2_i),
        .idRs1Val_i(idRs1Val_i), .idRs2Val_i(idRs2Val_i),
        .idImm_i(idImm_i), .idUseImm_i(idUseImm_i), .idRd_i(idRd_i),
        .idRegWrite_i(idRegWrite_i), .idMemRead_i(idMemRead_i),
        .idMemWrite_i(idMemWrite_i), .idBranch_i(idBranch_i),
        .exmemRd_i(exmemRd_i), .exmemRegWrite_i(exmemRegWrite_i), .exmemResult_i(exmemResult_i),
        .memwbRd_i(memwbRd_i), .memwbRegWrite_i(memwbRegWrite_i), .memwbResult_i(memwbResult_i),
        .flush_i(flush_i), .exHold_i(exHold_i),
        .aluCntrl_o(aluCntrl_o), .inv_o(inv_o),
        .srcA_o(srcA_o), .srcB_o(srcB_o), .storeData_o(storeData_o),
        .exValid_o(exValid_o), .exRd_o(exRd_o), .exRegWrite_o(exRegWrite_o),
        .exMemRead_o(exMemRead_o), .exMemWrite_o(exMemWrite_o), .exBranch_o(exBranch_o),
        .luBubbleCnt_o(luBubbleCnt_o)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_all();
        idValid_i = 1'b0; idAluCntrl_i = 4'b0000; idInv_i = 1'b0;
        idRs1_i = 5'd0; idRs2_i = 5'd0; idUseRs1_i = 1'b0; idUseRs2_i = 1'b0;
        idRs1Val_i = 32'd0; idRs2Val_i = 32'd0; idImm_i = 32'd0; idUseImm_i = 1'b0;
        idRd_i = 5'd0; idRegWrite_i = 1'b0; idMemRead_i = 1'b0; idMemWrite_i = 1'b0; idBranch_i = 1'b0;
        exmemRd_i = 5'd0; exmemRegWrite_i = 1'b0; exmemResult_i = 32'd0;
        memwbRd_i = 5'd0; memwbRegWrite_i = 1'b0; memwbResult_i = 32'd0;
        flush_i = 1'b0; exHold_i = 1'b0;
    endtask

    // Present an R/I-type instruction on the ID side.
    task automatic put_id(input logic [3:0] alu, input logic [4:0] rs1, input logic [31:0] v1,
                          input logic [4:0] rs2, input logic [31:0] v2, input logic use2,
                          input logic useImm, input logic [31:0] imm, input logic [4:0] rd,
                          input logic memRead);
        idValid_i = 1'b1; idAluCntrl_i = alu; idInv_i = 1'b0;
        idRs1_i = rs1; idRs1Val_i = v1; idUseRs1_i = 1'b1;
        idRs2_i = rs2; idRs2Val_i = v2; idUseRs2_i = use2;
        idUseImm_i = useImm; idImm_i = imm; idRd_i = rd;
        idRegWrite_i = 1'b1; idMemRead_i = memRead; idMemWrite_i = 1'b0; idBranch_i = 1'b0;
    endtask

    initial begin
        clear_all();
        rstN_i = 1'b0;
        tick();
        check_eq("rst_exValid", {31'd0, exValid_o}, 32'd0);
        check_eq("rst_aluCntrl", {28'd0, aluCntrl_o}, 32'd0);
        check_eq("rst_srcA", srcA_o, 32'd0);
        check_eq("rst_cnt", {28'd0, luBubbleCnt_o}, 32'd0);
        check_eq("rst_idReady", {31'd0, idReady_o}, 32'd1);
        rstN_i = 1'b1;

        // add x3,x1,x2 with x1=5, x2=7
        put_id(4'b0000, 5'd1, 32'd5, 5'd2, 32'd7, 1'b1, 1'b0, 32'd0, 5'd3, 1'b0);
        tick();
        check_eq("add_alu", {28'd0, aluCntrl_o}, 32'd0);
        check_eq("add_srcA", srcA_o, 32'd5);
        check_eq("add_srcB", srcB_o, 32'd7);
        check_eq("add_valid", {31'd0, exValid_o}, 32'd1);
        check_eq("add_rd", {27'd0, exRd_o}, 32'd3);

        // Forwarding priority on rs1=3, imm on srcB while storeData keeps rs2
        put_id(4'b0000, 5'd3, 32'h99, 5'd2, 32'd7, 1'b1, 1'b1, 32'd4, 5'd8, 1'b0);
        tick();
        exmemRd_i = 5'd3; exmemRegWrite_i = 1'b1; exmemResult_i = 32'h10;
        memwbRd_i = 5'd3; memwbRegWrite_i = 1'b1; memwbResult_i = 32'h20;
        #1;
        check_eq("fwd_exmem", srcA_o, 32'h10);
        check_eq("fwd_srcB_imm", srcB_o, 32'd4);
        check_eq("fwd_store_reg", storeData_o, 32'd7);
        exmemRegWrite_i = 1'b0;
        #1;
        check_eq("fwd_memwb", srcA_o, 32'h20);
        memwbRegWrite_i = 1'b0;
        #1;
        check_eq("fwd_none", srcA_o, 32'h99);
        memwbRd_i = 5'd2; memwbRegWrite_i = 1'b1;
        #1;
        check_eq("fwd_store_memwb", storeData_o, 32'h20);
        check_eq("fwd_srcB_still_imm", srcB_o, 32'd4);
        memwbRegWrite_i = 1'b0;

        // x0 is never forwarded
        put_id(4'b0000, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0, 5'd9, 1'b0);
        tick();
        exmemRd_i = 5'd0; exmemRegWrite_i = 1'b1; exmemResult_i = 32'hDEAD;
        memwbRd_i = 5'd0; memwbRegWrite_i = 1'b1; memwbResult_i = 32'hBEEF;
        #1;
        check_eq("x0_srcA", srcA_o, 32'd0);
        check_eq("x0_srcB", srcB_o, 32'd0);
        exmemRegWrite_i = 1'b0; memwbRegWrite_i = 1'b0;

        // lw x4 then addi x5,x4,1: one stall, one bubble, then capture
        put_id(4'b0000, 5'd1, 32'd5, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0, 5'd4, 1'b1);
        tick();
        put_id(4'b0000, 5'd4, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd1, 5'd5, 1'b0);
        #1;
        check_eq("lu_ready", {31'd0, idReady_o}, 32'd0);
        tick();
        check_eq("lu_bubble_valid", {31'd0, exValid_o}, 32'd0);
        check_eq("lu_bubble_rd", {27'd0, exRd_o}, 32'd0);
        check_eq("lu_cnt", {28'd0, luBubbleCnt_o}, 32'd1);
        check_eq("lu_ready_after", {31'd0, idReady_o}, 32'd1);
        tick();
        check_eq("lu_capture_valid", {31'd0, exValid_o}, 32'd1);
        check_eq("lu_capture_rd", {27'd0, exRd_o}, 32'd5);
        check_eq("lu_capture_srcB", srcB_o, 32'd1);

        // Load to x0 never creates a hazard
        put_id(4'b0000, 5'd1, 32'd5, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0, 5'd0, 1'b1);
        tick();
        put_id(4'b0000, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd1, 5'd5, 1'b0);
        #1;
        check_eq("lu_x0_ready", {31'd0, idReady_o}, 32'd1);
        tick();

        // Flush with a load-use pending: bubble, counter unchanged
        put_id(4'b0000, 5'd1, 32'd5, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0, 5'd4, 1'b1);
        tick();
        put_id(4'b0000, 5'd4, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd1, 5'd5, 1'b0);
        flush_i = 1'b1;
        #1;
        check_eq("flush_ready_unaffected", {31'd0, idReady_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        check_eq("flush_valid", {31'd0, exValid_o}, 32'd0);
        check_eq("flush_cnt", {28'd0, luBubbleCnt_o}, 32'd1);

        // Hold for three cycles: outputs frozen, flush ignored while held
        put_id(4'b1000, 5'd1, 32'd5, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 5'd6, 1'b0);
        tick();
        exHold_i = 1'b1;
        put_id(4'b1111, 5'd2, 32'd9, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 5'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            flush_i = (i == 1);
            #1;
            check_eq("hold_ready", {31'd0, idReady_o}, 32'd0);
            tick();
            check_eq("hold_alu", {28'd0, aluCntrl_o}, 32'h8);
            check_eq("hold_rd", {27'd0, exRd_o}, 32'd6);
            check_eq("hold_valid", {31'd0, exValid_o}, 32'd1);
        end
        flush_i = 1'b0;
        exHold_i = 1'b0;
        tick();
        check_eq("release_rd", {27'd0, exRd_o}, 32'd7);

        // Saturate: lw x4,0(x4) repeatedly gives one bubble every two cycles
        idValid_i = 1'b0;
        tick();
        put_id(4'b0000, 5'd4, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0, 5'd4, 1'b1);
        for (int i = 0; i < 40; i++) tick();
        check_eq("sat_cnt", {28'd0, luBubbleCnt_o}, 32'hF);
        tick();
        check_eq("sat_stall_pending", {31'd0, idReady_o}, 32'd0);
        tick();
        check_eq("sat_no_wrap", {28'd0, luBubbleCnt_o}, 32'hF);
        tick();

        // Reset during a pending stall with hold asserted
        check_eq("pre_rst_stall", {31'd0, idReady_o}, 32'd0);
        exHold_i = 1'b1;
        rstN_i = 1'b0;
        tick();
        check_eq("midrst_valid", {31'd0, exValid_o}, 32'd0);
        check_eq("midrst_cnt", {28'd0, luBubbleCnt_o}, 32'd0);
        check_eq("midrst_rd", {27'd0, exRd_o}, 32'd0);
        check_eq("midrst_ready_hold", {31'd0, idReady_o}, 32'd0);
        exHold_i = 1'b0;
        #1;
        check_eq("midrst_ready", {31'd0, idReady_o}, 32'd1);
        rstN_i = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
